// File: rtl/ext_bus_sequencer_pkg.sv
// Shared types and constants for the external byte-bus sequencer.
package ext_bus_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    TURN,
    RDATA,
    DONE
  } state_e;

  // Command byte bit positions
  localparam int CMD_START = 7;
  localparam int CMD_WE    = 6;

  // Read value returned on a timeout abort
  localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

  // Lane direction
  localparam logic [7:0] OE_DRIVE = 8'hFF;
  localparam logic [7:0] OE_IN    = 8'h00;

  // Pick byte idx (LSB first) out of a 32-bit word
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ext_bus_sequencer_bus_wait_timer.sv
// Counts consecutive stalled cycles and flags the cycle that hits the limit.
module bus_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam logic       TMO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TMO_LAST = TMO_EN ? 8'(TIMEOUT - 1) : 8'd0;

  logic [7:0] cnt;

  // Saturating stall counter, cleared by any non-stalled cycle
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= 8'd0;
    else if (count && cnt != 8'hFF) cnt <= cnt + 8'd1;
  end

  // Expire in the stalled cycle that brings the count up to TIMEOUT
  assign expire = TMO_EN && count && (cnt == TMO_LAST);

endmodule

// File: rtl/ext_bus_sequencer.sv
// Handshaked CPU-to-byte-bus transaction sequencer (command, address, data beats).
module ext_bus_sequencer
  import ext_bus_sequencer_pkg::*;
#(
  parameter int ADDR_BYTES = 4,
  parameter int DATA_BYTES = 4,
  parameter int TURNAROUND = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic        cpu_busy,
  output logic [7:0]  bus_ctl,
  output logic [7:0]  bus_dout,
  output logic [7:0]  bus_oe,
  input  logic [7:0]  bus_din,
  input  logic        bus_wait
);

  // Writes run as many beats as the longer of address and data
  localparam int         W_BEATS = (DATA_BYTES > ADDR_BYTES) ? DATA_BYTES : ADDR_BYTES;
  localparam logic [2:0] A_LAST  = 3'(ADDR_BYTES - 1);
  localparam logic [2:0] D_LAST  = 3'(DATA_BYTES - 1);
  localparam logic [2:0] W_LAST  = 3'(W_BEATS - 1);
  localparam logic [2:0] T_LAST  = 3'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  state_e      state, state_nxt;
  logic [2:0]  beat, beat_nxt;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic        cnt_en, expire;

  assign cnt_en = ((state == ADDR) || (state == RDATA)) && bus_wait;

  bus_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!cnt_en),
    .count  (cnt_en),
    .expire (expire)
  );

  // State, beat counter, latched request and CPU result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= 3'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      cpu_rdata <= 32'd0;
      cpu_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      if (state == IDLE && cpu_req) begin
        we_q      <= cpu_we;
        addr_q    <= cpu_addr;
        wdata_q   <= cpu_wdata;
        cpu_err   <= 1'b0;
        cpu_rdata <= 32'd0;
      end
      if (expire) begin
        cpu_err   <= 1'b1;
        cpu_rdata <= ERR_RDATA;
      end else if (state == RDATA && !bus_wait) begin
        cpu_rdata[{beat[1:0], 3'b000} +: 8] <= bus_din;
      end
    end
  end

  // Next-state, beat advance and bus byte mux, all decoded from registered state
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    bus_ctl   = 8'd0;
    bus_dout  = 8'd0;
    bus_oe    = OE_IN;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          state_nxt = CMD;
          beat_nxt  = 3'd0;
        end
      end
      CMD: begin
        bus_ctl[CMD_START] = 1'b1;
        bus_ctl[CMD_WE]    = we_q;
        bus_oe             = we_q ? OE_DRIVE : OE_IN;
        state_nxt          = ADDR;
        beat_nxt           = 3'd0;
      end
      ADDR: begin
        if (beat <= A_LAST) bus_ctl = byte_sel(addr_q, beat[1:0]);
        if (we_q) begin
          bus_oe = OE_DRIVE;
          if (beat <= D_LAST) bus_dout = byte_sel(wdata_q, beat[1:0]);
        end
        if (expire) begin
          state_nxt = DONE;
        end else if (!bus_wait) begin
          if (beat == (we_q ? W_LAST : A_LAST)) begin
            beat_nxt  = 3'd0;
            state_nxt = we_q ? DONE : ((TURNAROUND == 0) ? RDATA : TURN);
          end else begin
            beat_nxt = beat + 3'd1;
          end
        end
      end
      TURN: begin
        if (beat == T_LAST) begin
          beat_nxt  = 3'd0;
          state_nxt = RDATA;
        end else begin
          beat_nxt = beat + 3'd1;
        end
      end
      RDATA: begin
        if (expire) begin
          state_nxt = DONE;
        end else if (!bus_wait) begin
          if (beat == D_LAST) begin
            beat_nxt  = 3'd0;
            state_nxt = DONE;
          end else begin
            beat_nxt = beat + 3'd1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_ready = (state == DONE);
  assign cpu_busy  = (state != IDLE);

endmodule

// File: tb/tb_ext_bus_sequencer.sv
// Trace-driven bench: each scenario expands into per-cycle stimulus plus expected outputs.
module tb_ext_bus_sequencer;

  localparam int AB  = 4;
  localparam int DB  = 4;
  localparam int TA  = 1;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ready, cpu_err, cpu_busy;
  logic [31:0] cpu_rdata;
  logic [7:0]  bus_ctl, bus_dout, bus_oe;
  logic [7:0]  bus_din = '0;
  logic        bus_wait = 1'b0;

  ext_bus_sequencer #(.ADDR_BYTES(AB), .DATA_BYTES(DB), .TURNAROUND(TA), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .cpu_busy(cpu_busy), .bus_ctl(bus_ctl), .bus_dout(bus_dout), .bus_oe(bus_oe),
    .bus_din(bus_din), .bus_wait(bus_wait)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, req, we;
    logic [31:0] addr, wdata;
    logic        wt;
    logic [7:0]  din;
    logic [7:0]  ctl, dout, oe;
    logic        ready, busy, chk_err, chk_rd, err;
    logic [31:0] rdata;
  } cyc_t;

  typedef int w4_t[4];

  cyc_t q[$];
  cyc_t cur;
  logic cur_v = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    return w[8*k +: 8];
  endfunction

  function automatic cyc_t blank();
    cyc_t c;
    c.rst = 0; c.req = 0; c.we = 0; c.addr = '0; c.wdata = '0; c.wt = 0; c.din = '0;
    c.ctl = '0; c.dout = '0; c.oe = '0; c.ready = 0; c.busy = 0;
    c.chk_err = 0; c.chk_rd = 0; c.err = 0; c.rdata = '0;
    return c;
  endfunction

  task automatic push_idle(input logic req, input logic we, input logic [31:0] a, input logic [31:0] wd);
    cyc_t c = blank();
    c.req = req; c.we = we; c.addr = a; c.wdata = wd;
    q.push_back(c);
  endtask

  // Completion cycle; CPU still holds req with scrambled fields, which must be ignored
  task automatic push_done(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic err, input logic [31:0] rd);
    cyc_t c = blank();
    c.req = 1; c.we = ~we; c.addr = ~a; c.wdata = ~wd;
    c.ready = 1; c.busy = 1; c.chk_err = 1; c.err = err;
    c.chk_rd = err || !we; c.rdata = rd;
    q.push_back(c);
  endtask

  // One transaction from CMD to DONE; aw/rw give stall cycles per beat; rst_j>=0 resets at that read beat
  task automatic push_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input w4_t aw, input w4_t rw, input int rst_j);
    cyc_t c = blank();
    int   n;
    c.req = 1; c.we = ~we; c.addr = ~a; c.wdata = ~wd; c.busy = 1;
    c.ctl = {1'b1, we, 6'b0}; c.oe = we ? 8'hFF : 8'h00;
    q.push_back(c);
    n = we ? ((DB > AB) ? DB : AB) : AB;
    for (int i = 0; i < n; i++) begin
      c.ctl  = (i < AB) ? byte_of(a, i) : 8'h00;
      c.dout = (we && i < DB) ? byte_of(wd, i) : 8'h00;
      c.oe   = we ? 8'hFF : 8'h00;
      c.wt   = 1;
      if (aw[i] >= TMO) begin
        repeat (TMO) q.push_back(c);
        push_done(we, a, wd, 1'b1, 32'hFFFF_FFFF);
        return;
      end
      repeat (aw[i]) q.push_back(c);
      c.wt = 0;
      q.push_back(c);
    end
    if (!we) begin
      c.ctl = '0; c.dout = '0; c.oe = '0; c.wt = 0;
      repeat (TA) q.push_back(c);
      for (int j = 0; j < DB; j++) begin
        if (j == rst_j) begin
          c.rst = 1; c.din = 8'h5A;
          q.push_back(c);
          c = blank();
          c.chk_err = 1; c.chk_rd = 1;
          q.push_back(c);
          return;
        end
        c.wt = 1; c.din = 8'hEE;
        if (rw[j] >= TMO) begin
          repeat (TMO) q.push_back(c);
          push_done(we, a, wd, 1'b1, 32'hFFFF_FFFF);
          return;
        end
        repeat (rw[j]) q.push_back(c);
        c.wt = 0; c.din = byte_of(rd, j);
        q.push_back(c);
      end
    end
    push_done(we, a, wd, 1'b0, rd);
  endtask

  function automatic int ready_off(input int s);
    for (int k = s + 1; k < q.size(); k++) if (q[k].ready) return k - s;
    return -1;
  endfunction

  // Compare DUT against the current trace entry away from the active edge
  always @(negedge clk) begin
    if (cur_v) begin
      chk("bus_ctl", {24'd0, bus_ctl}, {24'd0, cur.ctl});
      chk("bus_dout", {24'd0, bus_dout}, {24'd0, cur.dout});
      chk("bus_oe", {24'd0, bus_oe}, {24'd0, cur.oe});
      chk("cpu_ready", {31'd0, cpu_ready}, {31'd0, cur.ready});
      chk("cpu_busy", {31'd0, cpu_busy}, {31'd0, cur.busy});
      if (cur.chk_err) chk("cpu_err", {31'd0, cpu_err}, {31'd0, cur.err});
      if (cur.chk_rd) chk("cpu_rdata", cpu_rdata, cur.rdata);
    end
  end

  initial begin
    w4_t nw, aw_w, rw_w, aw_t;
    int  s_wr, s_rd, s_wt, s_to;
    logic [7:0] exp_ctl[5];
    logic [7:0] exp_dout[4];
    cyc_t c;

    nw   = '{0, 0, 0, 0};
    aw_w = '{0, 0, 3, 0};
    rw_w = '{0, 2, 0, 0};
    aw_t = '{9, 0, 0, 0};

    // Reset state
    c = blank(); c.rst = 1; c.chk_err = 1; c.chk_rd = 1;
    q.push_back(c); q.push_back(c);
    push_idle(0, 0, 0, 0);
    // Plain write
    s_wr = q.size();
    push_idle(1, 1, 32'hDEADBEEF, 32'h12345678);
    push_txn(1, 32'hDEADBEEF, 32'h12345678, 0, nw, nw, -1);
    push_idle(0, 0, 0, 0);
    // Plain read
    s_rd = q.size();
    push_idle(1, 0, 32'h00000010, 0);
    push_txn(0, 32'h00000010, 0, 32'hD4C3B2A1, nw, nw, -1);
    push_idle(0, 0, 0, 0);
    // Read with stalls in address and data phases
    s_wt = q.size();
    push_idle(1, 0, 32'h00000010, 0);
    push_txn(0, 32'h00000010, 0, 32'hD4C3B2A1, aw_w, rw_w, -1);
    push_idle(0, 0, 0, 0);
    // Stuck stall -> timeout, then a normal write
    s_to = q.size();
    push_idle(1, 0, 32'h00000020, 0);
    push_txn(0, 32'h00000020, 0, 0, aw_t, nw, -1);
    push_idle(1, 1, 32'h00000030, 32'hCAFEF00D);
    push_txn(1, 32'h00000030, 32'hCAFEF00D, 0, nw, nw, -1);
    push_idle(0, 0, 0, 0);
    // Reset at read beat 2, then a fresh read
    push_idle(1, 0, 32'h00000040, 0);
    push_txn(0, 32'h00000040, 0, 32'h11223344, nw, nw, 2);
    push_idle(1, 0, 32'h00000044, 0);
    push_txn(0, 32'h00000044, 0, 32'h0BADF00D, nw, nw, -1);
    push_idle(0, 0, 0, 0);
    // Back-to-back writes with req held high
    push_idle(1, 1, 32'hA5A5_0001, 32'h01020304);
    push_txn(1, 32'hA5A5_0001, 32'h01020304, 0, nw, nw, -1);
    push_idle(1, 1, 32'h5A5A_0002, 32'hF0E0D0C0);
    push_txn(1, 32'h5A5A_0002, 32'hF0E0D0C0, 0, nw, nw, -1);
    push_idle(0, 0, 0, 0);
    push_idle(0, 0, 0, 0);

    // Hand-derived anchors for the model itself
    exp_ctl  = '{8'hC0, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    exp_dout = '{8'h78, 8'h56, 8'h34, 8'h12};
    for (int k = 0; k < 5; k++) chk("model_wr_ctl", {24'd0, q[s_wr+1+k].ctl}, {24'd0, exp_ctl[k]});
    for (int k = 0; k < 4; k++) chk("model_wr_dout", {24'd0, q[s_wr+2+k].dout}, {24'd0, exp_dout[k]});
    chk("model_wr_latency", ready_off(s_wr), 6);
    chk("model_rd_latency", ready_off(s_rd), 11);
    chk("model_rd_word", q[s_rd+11].rdata, 32'hD4C3B2A1);
    chk("model_wait_latency", ready_off(s_wt), 16);
    chk("model_tmo_latency", ready_off(s_to), 6);

    // Drive the trace, one entry per clock
    @(posedge clk);
    foreach (q[k]) begin
      #1;
      rst = q[k].rst; cpu_req = q[k].req; cpu_we = q[k].we;
      cpu_addr = q[k].addr; cpu_wdata = q[k].wdata;
      bus_wait = q[k].wt; bus_din = q[k].din;
      cur = q[k]; cur_v = 1'b1;
      @(posedge clk);
    end
    #1 cur_v = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
